// File: rtl/inst_loader.sv
// Streams a big-endian byte image (word count header + words) into instruction memory.
// Optional trailing checksum of all words is enabled by defining LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, DONE, ERR, CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, DONE, ERR
  } state_t;
`endif

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_q;
  logic [1:0]  bcnt_q;
  logic [17:0] idx_q;
  logic [31:0] n_q;
  logic [31:0] word_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        done_q;
  logic        err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  logic [31:0] shift_d;
  logic        blast;
  logic [17:0] idx_d;
  logic        wlast;
  logic        take;

  assign shift_d = {word_q[23:0], byte_data};
  assign blast   = (bcnt_q == 2'd3);
  assign idx_d   = idx_q + 18'd1;
  assign wlast   = ({14'd0, idx_d} == n_q);
  assign take    = byte_valid & byte_ready;

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == HDR) | (state_q == DATA)
                    | (state_q == CHK);
  assign busy = byte_ready | (state_q == WRITE);
`else
  assign byte_ready = (state_q == HDR) | (state_q == DATA);
  assign busy = byte_ready | (state_q == WRITE);
`endif

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bcnt_q     <= 2'd0;
      idx_q      <= 18'd0;
      n_q        <= 32'd0;
      word_q     <= 32'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bcnt_q     <= 2'd0;
            idx_q      <= 18'd0;
            n_q        <= 32'd0;
            word_q     <= 32'd0;
            mem_addr_q <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
            state_q    <= HDR;
          end
        end
        HDR: begin
          if (take) begin
            bcnt_q <= bcnt_q + 2'd1;
            word_q <= shift_d;
            if (blast) begin
              n_q <= shift_d;
              if (shift_d > MAX_W) begin
                err_q   <= 1'b1;
                state_q <= ERR;
              end else if (shift_d == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= CHK;
`else
                done_q  <= 1'b1;
                state_q <= DONE;
`endif
              end else begin
                state_q <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (take) begin
            bcnt_q <= bcnt_q + 2'd1;
            word_q <= shift_d;
            if (blast) begin
              mem_data_q <= shift_d;
              mem_we_q   <= 1'b1;
              state_q    <= WRITE;
            end
          end
        end
        WRITE: begin
          idx_q      <= idx_d;
          mem_addr_q <= mem_addr_q + 32'd4;
`ifdef LOADER_CHECKSUM_EN
          sum_q      <= sum_q + mem_data_q;
          state_q    <= wlast ? CHK : DATA;
`else
          if (wlast) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= DATA;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (take) begin
            bcnt_q <= bcnt_q + 2'd1;
            word_q <= shift_d;
            if (blast) begin
              if (shift_d == sum_q) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                err_q   <= 1'b1;
                state_q <= ERR;
              end
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes queued by stimulus,
// popped and compared by a write monitor.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  inst_loader dut (
    .clk(clk), .rst(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_data, e[31:0]);
        chk("wr_ready", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("byte_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gaps);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic load(input logic [31:0] w[$], input bit gaps,
                      input bit pulse);
    logic [31:0] sum;
    sum = 32'd0;
    do_start();
    send_word(32'(w.size()), gaps);
    for (int i = 0; i < w.size(); i++) begin
      exp_q.push_back({32'(4 * i), w[i]});
      sum += w[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[i][31-8*k -: 8], gaps);
        if (pulse && i == 0 && k == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(sum, gaps);
`endif
    wait_idle("load_idle");
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({nm, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk({nm, "_data"}, mem_data, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    #1;
    chk_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // byte_valid in IDLE must not be taken
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // two-word continuous load
    w = '{32'h2401_0005, 32'h0000_0000};
    load(w, 1'b0, 1'b0);
    chk("l1_done", {31'd0, done}, 32'd1);
    chk("l1_err", {31'd0, err}, 32'd0);
    chk("l1_q", 32'(exp_q.size()), 32'd0);

    // empty image
    do_start();
    send_word(32'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0, 1'b0);
`endif
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_busy", {31'd0, busy}, 32'd0);

    // oversize header
    do_start();
    send_word(32'h0002_0001, 1'b0);
    chk("big_err", {31'd0, err}, 32'd1);
    chk("big_done", {31'd0, done}, 32'd0);
    chk("big_ready", {31'd0, byte_ready}, 32'd0);
    do_start();
    chk("restart_err", {31'd0, err}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    send_word(32'd1, 1'b0);
    exp_q.push_back({32'd0, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hDEAD_BEEF, 1'b0);
`endif
    wait_idle("rs_idle");
    chk("rs_done", {31'd0, done}, 32'd1);
    chk("rs_q", 32'(exp_q.size()), 32'd0);

    // N == MAX_WORDS accepted; reset mid-word aborts
    do_start();
    send_word(32'd131072, 1'b0);
    chk("max_err", {31'd0, err}, 32'd0);
    chk("max_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_idle", {31'd0, busy}, 32'd0);
    w = '{32'h0102_0304};
    load(w, 1'b0, 1'b0);
    chk("mid_done", {31'd0, done}, 32'd1);
    chk("mid_q", 32'(exp_q.size()), 32'd0);

    // gapped stream with a stray start in DATA
    w = '{32'h2401_0005, 32'h0000_0000, 32'hCAFE_F00D};
    load(w, 1'b1, 1'b1);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_err", {31'd0, err}, 32'd0);
    chk("gap_q", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    do_start();
    send_word(32'd1, 1'b0);
    exp_q.push_back({32'd0, 32'd1});
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    chk("cs_bad_err", {31'd0, err}, 32'd1);
    chk("cs_bad_done", {31'd0, done}, 32'd0);
    chk("cs_bad_q", 32'(exp_q.size()), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
